// File: rtl/eval_result_collector.sv
// eval_result_collector: follows eval_module with a valid/kernel delay line that
// lines the tags up with the fixed result latency. Aligned results go into a
// first-word-fall-through FIFO that drains through a valid/ready port.
// A wrapping checksum covers every result the FIFO accepts.
module eval_result_collector #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int CW      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_kernel,
    input  logic [7:0]                 eval_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_kernel,
    output logic [CW-1:0]              checksum,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    // Stage i holds the tag of the beat issued i edges ago.
    logic [LATENCY:1] vld_pipe;
    logic [LATENCY:1] knl_pipe;

    logic          push_v, push_k, pop, push_ok;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem_data [DEPTH];
    logic          mem_knl  [DEPTH];

    assign push_v  = vld_pipe[LATENCY];
    assign push_k  = knl_pipe[LATENCY];
    assign pop     = out_valid && out_ready;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push_ok = push_v && ((count != FULL) || pop);

    // Head is shown straight from registered state; zeroed when empty.
    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem_data[rd_ptr] : 8'd0;
    assign out_kernel = out_valid ? mem_knl[rd_ptr]  : 1'b0;

    // Delay line: reset flushes in-flight beats so they never reach the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            knl_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue_valid;
            knl_pipe[1] <= issue_kernel;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                knl_pipe[i] <= knl_pipe[i-1];
            end
        end
    end

    // FIFO storage; contents are don't-care while not covered by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= eval_result;
            mem_knl[wr_ptr]  <= push_k;
        end
    end

    // Pointers, occupancy, sticky overflow and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            checksum <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr   <= wr_ptr + AW'(1);
                checksum <= checksum + {{(CW-8){1'b0}}, eval_result};
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_v && !push_ok)
                overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_eval_result_collector.sv
// Directed bench for eval_result_collector. eval_result is driven by hand with the
// value eval_module would produce, present only on the cycle the result is due.
module tb_eval_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_kernel, out_ready;
    logic [7:0]  eval_result;
    logic        out_valid, out_kernel, overflow;
    logic [7:0]  out_data;
    logic [15:0] checksum;
    logic [3:0]  count;

    int n_chk  = 0;
    int n_pass = 0;
    int pops;

    eval_result_collector #(.LATENCY(4), .DEPTH(8), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_kernel(issue_kernel),
        .eval_result(eval_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_kernel(out_kernel),
        .checksum(checksum), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One active edge, then settle; inputs set after this are seen at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0; issue_kernel = 1'b0; out_ready = 1'b0; eval_result = 8'h5A;
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic k);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_knl"}, out_kernel, k);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // 1: reset then idle
        do_reset();
        repeat (10) tick();
        chk("rst_vld", out_valid, 0);
        chk("rst_cnt", count, 0);
        chk("rst_sum", checksum, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);

        // 2: single bypass beat, 00+00 -> FF at edge 4
        issue_valid = 1'b1; issue_kernel = 1'b0;
        tick();                          // edge 0
        issue_valid = 1'b0;
        repeat (3) tick();               // edges 1..3
        chk("t2_early_cnt", count, 0);
        eval_result = 8'hFF;
        tick();                          // edge 4: push
        eval_result = 8'h5A;
        chk("t2_cnt", count, 1);
        chk("t2_sum", checksum, 16'h00FF);
        pop_check("t2", 8'hFF, 1'b0);
        chk("t2_empty", out_valid, 0);

        // 3: kernel path, steady inputs -> 116 for every beat
        do_reset();
        issue_valid = 1'b1; issue_kernel = 1'b1;
        repeat (3) tick();               // edges 0..2
        issue_valid = 1'b0;
        tick();                          // edge 3
        eval_result = 8'd116;
        repeat (3) tick();               // edges 4..6
        eval_result = 8'h5A;
        chk("t3_cnt", count, 3);
        for (int i = 0; i < 3; i++) pop_check("t3", 8'd116, 1'b1);

        // 3b: issue order preserved with distinct results and kernel pattern
        do_reset();
        issue_valid = 1'b1;
        issue_kernel = 1'b1; tick();
        issue_kernel = 1'b0; tick();
        issue_kernel = 1'b1; tick();     // edges 0..2
        issue_valid = 1'b0; issue_kernel = 1'b0;
        tick();                          // edge 3
        eval_result = 8'h11; tick();
        eval_result = 8'h22; tick();
        eval_result = 8'h33; tick();     // edges 4..6
        eval_result = 8'h5A;
        chk("t3b_sum", checksum, 16'h0066);
        pop_check("t3b_0", 8'h11, 1'b1);
        pop_check("t3b_1", 8'h22, 1'b0);
        pop_check("t3b_2", 8'h33, 1'b1);

        // 4: 9 pushes into an undrained FIFO
        do_reset();
        eval_result = 8'h10;
        issue_valid = 1'b1;
        repeat (9) tick();               // edges 0..8
        issue_valid = 1'b0;
        repeat (3) tick();               // edges 9..11: 8 pushes done
        chk("t4_cnt8", count, 8);
        chk("t4_ovf_pre", overflow, 0);
        tick();                          // edge 12: 9th dropped
        chk("t4_cnt", count, 8);
        chk("t4_ovf", overflow, 1);
        chk("t4_sum", checksum, 16'h0080);
        eval_result = 8'h5A;
        for (int i = 0; i < 8; i++) pop_check("t4_drain", 8'h10, 1'b0);
        chk("t4_drained", out_valid, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_no_underflow", count, 0);
        chk("t4_ovf_sticky", overflow, 1);

        // 5: full FIFO, simultaneous push and pop for 20 cycles
        do_reset();
        eval_result = 8'h01;
        pops = 0;
        for (int t = 0; t < 32; t++) begin
            issue_valid = (t < 28);
            out_ready   = (t >= 12);
            if (out_valid && out_ready) pops++;
            tick();
            if (t >= 11) chk("t5_cnt", count, 8);
        end
        issue_valid = 1'b0; out_ready = 1'b0; eval_result = 8'h5A;
        chk("t5_pops", pops, 20);
        chk("t5_ovf", overflow, 0);
        chk("t5_sum", checksum, 16'h001C);

        // 6: reset lands while beats are in flight
        issue_valid = 1'b1;
        tick(); tick();                  // edges 0,1
        rst = 1'b1;
        tick();                          // edge 2 with reset
        rst = 1'b0; issue_valid = 1'b0;
        eval_result = 8'hAA;
        repeat (8) tick();
        chk("t6_cnt", count, 0);
        chk("t6_sum", checksum, 0);
        chk("t6_vld", out_valid, 0);
        chk("t6_ovf", overflow, 0);

        // Checksum wraps: 258 * 0xFF = 0x100FE -> 0x00FE
        do_reset();
        eval_result = 8'hFF;
        out_ready = 1'b1;
        issue_valid = 1'b1;
        repeat (258) tick();
        issue_valid = 1'b0;
        repeat (8) tick();
        out_ready = 1'b0;
        chk("wrap_sum", checksum, 16'h00FE);
        chk("wrap_cnt", count, 0);
        chk("wrap_ovf", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
